batch_sample_mem: RTL and testbench
===================================

BATCH_SAMPLE_MEM -- requirements
Module: batch_sample_mem

Interface
REQ-001 SHALL have parameter depth, default 180: filter depth in input samples.
REQ-002 SHALL have parameter DSR, default 12: downsample ratio (bits per channel per word).
REQ-003 SHALL have parameter M, default 4: control-signal channels.
REQ-004 SHALL derive local constants: DSD = ceil(depth/DSR) (15 by default); WORDS = 4*DSD (60); AW = clog2(WORDS) (6); DW = M*DSR (48).
REQ-005 SHALL have port clk, input, 1 bit: single clock; same clock as the downsampled sample clock of the batch filter.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port sampleWrite, input, 1 bit: write enable.
REQ-008 SHALL have port sampleAddrIn, input, AW bits: write address {batch count, cycle[1:0]}.
REQ-009 SHALL have port sampleDataIn, input, DW bits: write data.
REQ-010 SHALL have ports sampleAddrOut1/2/3, input, AW bits each: read addresses (lookahead, forward, backward).
REQ-011 SHALL have ports sampleDataOut1/2/3, output, DW bits each: registered read data.
REQ-012 SHALL have port ready, output, 1 bit: high once memory clear completes.
REQ-013 SHALL have port collision, output, 1 bit: sticky flag, write/read same-address hit.
REQ-014 SHALL have port oor, output, 1 bit: sticky flag, out-of-range address used.

Function
REQ-015 SHALL hold WORDS words of DW bits; all ports synchronous to rising clk.
REQ-016 SHALL implement FSM states INIT and RUN; rst low forces INIT with clear counter = 0.
REQ-017 In INIT, SHALL write zero to word[counter] each cycle and increment the counter, moving to RUN after writing word WORDS-1; clear takes exactly WORDS cycles after rst deasserts.
REQ-018 ready SHALL be 0 in INIT and go to 1 on the first cycle in RUN.
REQ-019 In INIT, external writes SHALL be ignored and all sampleDataOutK SHALL register 0.
REQ-020 In RUN, a write with sampleWrite=1 and sampleAddrIn < WORDS SHALL update the word at that edge.
REQ-021 Read latency SHALL be 1 cycle: sampleDataOutK after edge t = word[sampleAddrOutK sampled at edge t], with the three read ports independent.
REQ-022 Read-during-write to the same address SHALL return the old data (read-first), with no bypass.
REQ-023 In RUN, collision SHALL set when sampleWrite=1 and sampleAddrIn equals any in-range sampleAddrOutK; it SHALL remain set until rst.
REQ-024 A write with sampleAddrIn >= WORDS SHALL be dropped and SHALL set oor.
REQ-025 A read with sampleAddrOutK >= WORDS SHALL register 0 on that port and SHALL set oor.
REQ-026 Neither flag SHALL set in INIT.
REQ-027 Simultaneous out-of-range and collision conditions SHALL set both flags independently.
REQ-028 Address wrap SHALL be the producer's responsibility; the block SHALL NOT wrap addresses internally.

Reset
REQ-029 On a clock edge with rst=0: state=INIT, counter=0, ready=0, collision=0, oor=0, sampleDataOut1/2/3=0.
REQ-030 Reset asserted mid-RUN or mid-INIT SHALL restart the full WORDS-cycle clear; previously written contents SHALL read 0 afterward.
REQ-031 Memory contents SHALL NOT be relied on before ready=1.

Verification
REQ-032 Scenario, clear: release rst, count cycles -> ready rises exactly 60 cycles after release; reads of addresses 0..59 return 0.
REQ-033 Scenario, latency: write 48'hA5A5_0000_1234 to address 7; next cycle set sampleAddrOut2=7 -> sampleDataOut2 = 48'hA5A5_0000_1234 one cycle later; ports 1 and 3 unaffected.
REQ-034 Scenario, read-first collision: address 9 holds 48'h1; same cycle write 48'h2 to 9 and read 9 on port 3 -> port 3 returns 48'h1, collision=1; next read of 9 returns 48'h2; collision stays 1.
REQ-035 Scenario, out of range: write to address 62 and read address 61 on port 1 -> no word changes, sampleDataOut1=0, oor=1.
REQ-036 Scenario, reset mid-operation: write 48'hFFFF_FFFF_FFFF to address 3, pulse rst low for 1 cycle during RUN -> ready=0 for 60 cycles; afterward address 3 reads 0; flags cleared.
REQ-037 Scenario, batch streaming: drive 4*15 writes with addr {batCnt, cycle} while reading {batCntRev, cycle+3} and {batCnt, cycle+1} -> reads match scoreboard and collision stays 0.

Source files
------------

// File: rtl/batch_sample_mem.sv
// Three-read, one-write sample store for the batch filter.
// Self-clears after reset; flags collisions and out-of-range accesses.
module batch_sample_mem #(
  parameter  int depth = 180,
  parameter  int DSR   = 12,
  parameter  int M     = 4,
  localparam int DSD   = (depth + DSR - 1) / DSR,
  localparam int WORDS = 4 * DSD,
  localparam int AW    = $clog2(WORDS),
  localparam int DW    = M * DSR
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sampleWrite,
  input  logic [AW-1:0] sampleAddrIn,
  input  logic [DW-1:0] sampleDataIn,
  input  logic [AW-1:0] sampleAddrOut1,
  input  logic [AW-1:0] sampleAddrOut2,
  input  logic [AW-1:0] sampleAddrOut3,
  output logic [DW-1:0] sampleDataOut1,
  output logic [DW-1:0] sampleDataOut2,
  output logic [DW-1:0] sampleDataOut3,
  output logic          ready,
  output logic          collision,
  output logic          oor
);

  localparam logic [AW-1:0] LAST = AW'(WORDS - 1);

  typedef enum logic {INIT, RUN} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          col_q, col_d;
  logic          oor_q, oor_d;
  logic [DW-1:0] rd_q [3];
  logic [DW-1:0] rd_d [3];
  logic [AW-1:0] ra   [3];
  logic [DW-1:0] mem_q [WORDS];

  logic          we;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;

  function automatic logic in_rng(input logic [AW-1:0] a);
    return a <= LAST;
  endfunction

  assign ra[0] = sampleAddrOut1;
  assign ra[1] = sampleAddrOut2;
  assign ra[2] = sampleAddrOut3;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
      col_q   <= 1'b0;
      oor_q   <= 1'b0;
      rd_q    <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      oor_q   <= oor_d;
      rd_q    <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && we) mem_q[wa] <= wd;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
      end
    endcase
  end

  // Reads sample the array before this edge's write: read-first, no bypass.
  always_comb begin
    we    = 1'b0;
    wa    = cnt_q;
    wd    = '0;
    col_d = col_q;
    oor_d = oor_q;
    rd_d  = '{default: '0};
    if (state_q == INIT) begin
      we = 1'b1;
    end else begin
      if (sampleWrite) begin
        if (in_rng(sampleAddrIn)) begin
          we = 1'b1;
          wa = sampleAddrIn;
          wd = sampleDataIn;
        end else begin
          oor_d = 1'b1;
        end
      end
      for (int k = 0; k < 3; k++) begin
        if (in_rng(ra[k])) begin
          rd_d[k] = mem_q[ra[k]];
          if (sampleWrite && ra[k] == sampleAddrIn) col_d = 1'b1;
        end else begin
          oor_d = 1'b1;
        end
      end
    end
  end

  assign ready          = (state_q == RUN);
  assign collision      = col_q;
  assign oor            = oor_q;
  assign sampleDataOut1 = rd_q[0];
  assign sampleDataOut2 = rd_q[1];
  assign sampleDataOut3 = rd_q[2];

endmodule

// File: tb/tb_batch_sample_mem.sv
// Directed bench for batch_sample_mem: vector table plus
// clear, reset and streaming sequences.
module tb_batch_sample_mem;

  localparam int WORDS = 60;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [5:0]  wa;
  logic [47:0] wd;
  logic [5:0]  ra1, ra2, ra3;
  logic [47:0] rd1, rd2, rd3;
  logic        ready, collision, oor;

  int n_cmp = 0;
  int n_err = 0;

  batch_sample_mem dut (
    .clk            (clk),
    .rst            (rst),
    .sampleWrite    (we),
    .sampleAddrIn   (wa),
    .sampleDataIn   (wd),
    .sampleAddrOut1 (ra1),
    .sampleAddrOut2 (ra2),
    .sampleAddrOut3 (ra3),
    .sampleDataOut1 (rd1),
    .sampleDataOut2 (rd2),
    .sampleDataOut3 (rd3),
    .ready          (ready),
    .collision      (collision),
    .oor            (oor)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [5:0]  wa;
    logic [47:0] wd;
    logic [5:0]  ra1, ra2, ra3;
    logic [47:0] e1, e2, e3;
    logic        ecol, eoor;
  } vec_t;

  vec_t vec [10];

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [47:0] act,
                     input logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    we = 1'b0; wa = '0; wd = '0;
    ra1 = '0; ra2 = '0; ra3 = '0;
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (!ready && cyc < 200) begin
      step();
      cyc++;
    end
  endtask

  task automatic reset_pulse();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  logic [47:0] sb [WORDS];
  int cyc;

  initial begin
    vec[0] = '{1'b1, 6'd7,  48'hA5A5_0000_1234, 6'd0,  6'd0,  6'd0,
               48'h0, 48'h0, 48'h0, 1'b0, 1'b0};
    vec[1] = '{1'b0, 6'd0,  48'h0, 6'd1,  6'd7,  6'd2,
               48'h0, 48'hA5A5_0000_1234, 48'h0, 1'b0, 1'b0};
    vec[2] = '{1'b1, 6'd9,  48'h1, 6'd0,  6'd0,  6'd0,
               48'h0, 48'h0, 48'h0, 1'b0, 1'b0};
    vec[3] = '{1'b1, 6'd9,  48'h2, 6'd0,  6'd7,  6'd9,
               48'h0, 48'hA5A5_0000_1234, 48'h1, 1'b1, 1'b0};
    vec[4] = '{1'b0, 6'd0,  48'h0, 6'd9,  6'd9,  6'd9,
               48'h2, 48'h2, 48'h2, 1'b1, 1'b0};
    vec[5] = '{1'b1, 6'd62, 48'hFFFF_FFFF_FFFF, 6'd61, 6'd9, 6'd7,
               48'h0, 48'h2, 48'hA5A5_0000_1234, 1'b1, 1'b1};
    vec[6] = '{1'b1, 6'd59, 48'h0000_BEEF_0001, 6'd59, 6'd60, 6'd5,
               48'h0, 48'h0, 48'h0, 1'b1, 1'b1};
    vec[7] = '{1'b0, 6'd0,  48'h0, 6'd59, 6'd63, 6'd3,
               48'h0000_BEEF_0001, 48'h0, 48'h0, 1'b1, 1'b1};
    vec[8] = '{1'b1, 6'd60, 48'h123, 6'd59, 6'd59, 6'd0,
               48'h0000_BEEF_0001, 48'h0000_BEEF_0001, 48'h0, 1'b1, 1'b1};
    vec[9] = '{1'b0, 6'd0,  48'h0, 6'd59, 6'd0,  6'd2,
               48'h0000_BEEF_0001, 48'h0, 48'h0, 1'b1, 1'b1};

    idle();
    rst = 1'b0;
    step();
    step();
    chk("rst_ready", 48'(ready), 48'h0);
    chk("rst_col",   48'(collision), 48'h0);
    chk("rst_oor",   48'(oor), 48'h0);
    chk("rst_rd1",   rd1, 48'h0);

    // Traffic during clear must be ignored and raise no flags.
    we = 1'b1; wa = 6'd5; wd = 48'hDEAD_DEAD_DEAD;
    ra1 = 6'd63; ra2 = 6'd5; ra3 = 6'd0;
    @(negedge clk);
    rst = 1'b1;
    wait_ready(cyc);
    chk("clear_cycles", 48'(cyc), 48'd60);
    chk("init_rd2",     rd2, 48'h0);
    idle();
    step();
    chk("init_col", 48'(collision), 48'h0);
    chk("init_oor", 48'(oor), 48'h0);

    for (int a = 0; a < WORDS; a++) begin
      ra1 = 6'(a);
      step();
      chk($sformatf("clear_rd_%0d", a), rd1, 48'h0);
    end

    foreach (vec[i]) begin
      we = vec[i].we; wa = vec[i].wa; wd = vec[i].wd;
      ra1 = vec[i].ra1; ra2 = vec[i].ra2; ra3 = vec[i].ra3;
      step();
      chk($sformatf("v%0d_rd1", i), rd1, vec[i].e1);
      chk($sformatf("v%0d_rd2", i), rd2, vec[i].e2);
      chk($sformatf("v%0d_rd3", i), rd3, vec[i].e3);
      chk($sformatf("v%0d_col", i), 48'(collision), 48'(vec[i].ecol));
      chk($sformatf("v%0d_oor", i), 48'(oor), 48'(vec[i].eoor));
    end

    // Reset mid-run wipes contents and flags.
    idle();
    we = 1'b1; wa = 6'd3; wd = 48'hFFFF_FFFF_FFFF;
    step();
    idle();
    reset_pulse();
    chk("mrst_ready", 48'(ready), 48'h0);
    chk("mrst_col",   48'(collision), 48'h0);
    chk("mrst_oor",   48'(oor), 48'h0);
    wait_ready(cyc);
    chk("mrst_cycles", 48'(cyc), 48'd60);
    ra1 = 6'd3; ra2 = 6'd59; ra3 = 6'd7;
    step();
    chk("mrst_rd3",  rd1, 48'h0);
    chk("mrst_rd59", rd2, 48'h0);
    chk("mrst_rd7",  rd3, 48'h0);
    chk("mrst_col2", 48'(collision), 48'h0);
    chk("mrst_oor2", 48'(oor), 48'h0);

    // Collision and out-of-range in the same cycle.
    we = 1'b1; wa = 6'd5; wd = 48'h7;
    ra1 = 6'd5; ra2 = 6'd63; ra3 = 6'd0;
    step();
    chk("both_col", 48'(collision), 48'h1);
    chk("both_oor", 48'(oor), 48'h1);
    idle();

    // Reset during clear restarts the full clear.
    reset_pulse();
    repeat (20) step();
    chk("irst_ready", 48'(ready), 48'h0);
    reset_pulse();
    wait_ready(cyc);
    chk("irst_cycles", 48'(cyc), 48'd60);
    chk("irst_col", 48'(collision), 48'h0);
    chk("irst_oor", 48'(oor), 48'h0);

    foreach (sb[i]) sb[i] = '0;
    for (int p = 0; p < 2; p++) begin
      for (int b = 0; b < 15; b++) begin
        for (int c = 0; c < 4; c++) begin
          logic [47:0] x1, x2;
          we  = 1'b1;
          wa  = 6'(b * 4 + c);
          wd  = {16'(p), 16'(b), 16'(c)} ^ 48'h5A5A_A5A5_3C3C;
          ra1 = 6'((14 - b) * 4 + ((c + 3) % 4));
          ra2 = 6'(b * 4 + ((c + 1) % 4));
          ra3 = ra1;
          x1  = sb[ra1];
          x2  = sb[ra2];
          sb[wa] = wd;
          step();
          if (rd1 !== x1 || rd2 !== x2 || rd3 !== x1) begin
            chk($sformatf("strm_p%0d_b%0d_c%0d_rd1", p, b, c), rd1, x1);
            chk($sformatf("strm_p%0d_b%0d_c%0d_rd2", p, b, c), rd2, x2);
            chk($sformatf("strm_p%0d_b%0d_c%0d_rd3", p, b, c), rd3, x1);
          end else begin
            n_cmp += 3;
          end
        end
      end
    end
    idle();
    chk("strm_col", 48'(collision), 48'h0);
    chk("strm_oor", 48'(oor), 48'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
